// File: rtl/instr_uncached_fetch.sv
// Uncached instruction fetch: one single-beat AXI4 read per aligned request, word returned with a 1-cycle data_ok.
// Latency: data_ok in the R-beat cycle (3 cycles with a zero-wait slave); IF is held via stall; AR/R waits are honoured.
module instr_uncached_fetch #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cancel,
    output logic [31:0] instr,
    output logic        data_ok,
    output logic        bus_err,
    output logic        adel,
    output logic        stall,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        discard_q, discard_d;
    logic        adel_q, adel_d;

    logic aligned;
    logic beat_acc;
    logic deliver;

    assign aligned  = (addr[1:0] == 2'b00);
    assign beat_acc = (state_q == S_R) && rvalid && (rid == AXI_ID) && rlast;
    assign deliver  = beat_acc && !discard_q && !cancel;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        discard_d = discard_q;
        adel_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (aligned) begin
                        addr_d    = addr;
                        discard_d = 1'b0;
                        state_d   = S_AR;
                    end else begin
                        adel_d = 1'b1;
                    end
                end
            end
            S_AR: begin
                // The AR handshake must complete even when flushed; only the result is dropped.
                if (cancel) discard_d = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (beat_acc) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    if (deliver) instr_d = rdata;
                end else if (cancel) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            instr_q   <= 32'h0;
            discard_q <= 1'b0;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            discard_q <= discard_d;
            adel_q    <= adel_d;
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);

    assign data_ok = deliver;
    assign bus_err = deliver && (rresp != 2'b00);
    assign adel    = adel_q;
    assign instr   = deliver ? rdata : instr_q;

    // Gated by rst so IF is released the moment reset asserts, even with req held high.
    assign stall = rst && (((state_q == S_IDLE) && req && aligned)
                           || (state_q == S_AR)
                           || ((state_q == S_R) && !deliver));

endmodule

// File: tb/tb_instr_uncached_fetch.sv
// Directed per-cycle vector table for the uncached fetch engine, plus a reset-mid-transaction sequence.
module tb_instr_uncached_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        cancel;
    logic [31:0] instr;
    logic        data_ok, bus_err, adel, stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_uncached_fetch #(.AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .cancel(cancel),
        .instr(instr), .data_ok(data_ok), .bus_err(bus_err), .adel(adel), .stall(stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        cancel;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        e_stall;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_rready;
        logic        e_dok;
        logic        e_berr;
        logic        e_adel;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rq, input logic [31:0] a, input logic cn, input logic ar,
                       input logic rv, input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs,
                       input logic st, input logic av, input logic [31:0] aa, input logic rr,
                       input logic ok, input logic be, input logic ad, input logic [31:0] ins);
        vec_t v;
        v = '{rq, a, cn, ar, rv, id, d, rs, st, av, aa, rr, ok, be, ad, ins};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        req = 1'b0; addr = 32'h0; cancel = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rid = 4'd1; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic check_row(input int row, input vec_t v);
        chk("stall",   row, {31'h0, stall},   {31'h0, v.e_stall});
        chk("arvalid", row, {31'h0, arvalid}, {31'h0, v.e_arvalid});
        if (v.e_arvalid) begin
            chk("araddr", row, araddr, v.e_araddr);
            chk("arlen",  row, {24'h0, arlen},  32'h0);
            chk("arsize", row, {29'h0, arsize}, 32'd2);
        end
        chk("rready",  row, {31'h0, rready},  {31'h0, v.e_rready});
        chk("data_ok", row, {31'h0, data_ok}, {31'h0, v.e_dok});
        chk("bus_err", row, {31'h0, bus_err}, {31'h0, v.e_berr});
        chk("adel",    row, {31'h0, adel},    {31'h0, v.e_adel});
        chk("instr",   row, instr, v.e_instr);
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        drive_idle();
        #1;
        chk("rst_arvalid", -1, {31'h0, arvalid}, 32'h0);
        chk("rst_rready",  -1, {31'h0, rready},  32'h0);
        chk("rst_dok",     -1, {31'h0, data_ok}, 32'h0);
        chk("rst_adel",    -1, {31'h0, adel},    32'h0);
        chk("rst_instr",   -1, instr, 32'h0);
        chk("rst_arid",    -1, {28'h0, arid},    32'h1);
        chk("rst_arburst", -1, {30'h0, arburst}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        //   req addr          cn ar rv id  rdata         rr     | st av araddr        rr ok be ad instr
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h0);
        // basic fetch, zero-wait slave
        add(1, 32'h1FC0_0000,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h0);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0000, 0, 0, 0, 0, 32'h0);
        add(0, 32'h0,          0, 0, 1, 1, 32'h2408_0001, 2'd0,  0, 0, 32'h0,         1, 1, 0, 0, 32'h2408_0001);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h2408_0001);
        // arready held low; live addr changes but araddr must not
        add(1, 32'h1FC0_0010,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h2408_0001);
        for (int i = 0; i < 5; i++)
            add(1, 32'h0000_0008 + 32'(i * 4), 0, 0, 0, 1, 32'h0, 2'd0, 1, 1, 32'h1FC0_0010, 0, 0, 0, 0, 32'h2408_0001);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0010, 0, 0, 0, 0, 32'h2408_0001);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         1, 0, 0, 0, 32'h2408_0001);
        add(0, 32'h0,          0, 0, 1, 1, 32'h1111_2222, 2'd0,  0, 0, 32'h0,         1, 1, 0, 0, 32'h1111_2222);
        // cancel during AR drops the result
        add(1, 32'h1FC0_0020,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h1111_2222);
        add(0, 32'h0,          1, 0, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0020, 0, 0, 0, 0, 32'h1111_2222);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0020, 0, 0, 0, 0, 32'h1111_2222);
        add(0, 32'h0,          0, 0, 1, 1, 32'hDEAD_BEEF, 2'd0,  1, 0, 32'h0,         1, 0, 0, 0, 32'h1111_2222);
        add(1, 32'h1FC0_0004,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h1111_2222);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0004, 0, 0, 0, 0, 32'h1111_2222);
        add(0, 32'h0,          0, 0, 1, 1, 32'h3333_4444, 2'd0,  0, 0, 32'h0,         1, 1, 0, 0, 32'h3333_4444);
        // misaligned request
        add(1, 32'h1FC0_0002,  0, 1, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h3333_4444);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 1, 32'h3333_4444);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h3333_4444);
        // foreign RID ignored, then SLVERR beat
        add(1, 32'h1FC0_0030,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h3333_4444);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0030, 0, 0, 0, 0, 32'h3333_4444);
        add(0, 32'h0,          0, 0, 1, 2, 32'h5555_6666, 2'd2,  1, 0, 32'h0,         1, 0, 0, 0, 32'h3333_4444);
        add(0, 32'h0,          0, 0, 1, 1, 32'h6666_7777, 2'd2,  0, 0, 32'h0,         1, 1, 1, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h6666_7777);
        // cancel coinciding with the R beat
        add(1, 32'h1FC0_0040,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0040, 0, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          1, 0, 1, 1, 32'hAAAA_BBBB, 2'd0,  1, 0, 32'h0,         1, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h6666_7777);
        // cancel while waiting in R, beat arrives later
        add(1, 32'h1FC0_0050,  0, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         0, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 1, 0, 1, 32'h0,         2'd0,  1, 1, 32'h1FC0_0050, 0, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          1, 0, 0, 1, 32'h0,         2'd0,  1, 0, 32'h0,         1, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 0, 1, 1, 32'hCCCC_DDDD, 2'd0,  1, 0, 32'h0,         1, 0, 0, 0, 32'h6666_7777);
        add(0, 32'h0,          0, 0, 0, 1, 32'h0,         2'd0,  0, 0, 32'h0,         0, 0, 0, 0, 32'h6666_7777);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            req = v.req; addr = v.addr; cancel = v.cancel; arready = v.arready;
            rvalid = v.rvalid; rid = v.rid; rdata = v.rdata; rresp = v.rresp; rlast = v.rvalid;
            #1;
            check_row(i, v);
        end

        // reset asserted while in R
        @(negedge clk); drive_idle(); req = 1'b1; addr = 32'h1FC0_0060;
        @(negedge clk); drive_idle(); arready = 1'b1;
        @(negedge clk); drive_idle();
        #1;
        chk("pre_rst_rready", 100, {31'h0, rready}, 32'h1);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_rst_arvalid", 101, {31'h0, arvalid}, 32'h0);
        chk("mid_rst_rready",  101, {31'h0, rready},  32'h0);
        chk("mid_rst_stall",   101, {31'h0, stall},   32'h0);
        chk("mid_rst_dok",     101, {31'h0, data_ok}, 32'h0);
        chk("mid_rst_instr",   101, instr, 32'h0);
        @(negedge clk); rst = 1'b1;

        // fetch after reset release, with a bounded wait for data_ok
        @(negedge clk); req = 1'b1; addr = 32'h1FC0_0000; arready = 1'b1;
        #1;
        chk("post_rst_stall", 102, {31'h0, stall}, 32'h1);
        @(negedge clk); req = 1'b0; addr = 32'h0;
        #1;
        chk("post_rst_araddr", 103, araddr, 32'h1FC0_0000);
        chk("post_rst_arvalid", 103, {31'h0, arvalid}, 32'h1);
        @(negedge clk); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 32'h2408_0001;
        begin
            int n;
            n = 0;
            #1;
            while (!data_ok && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("post_rst_dok_latency", 104, 32'(n), 32'd0);
        end
        chk("post_rst_dok",   104, {31'h0, data_ok}, 32'h1);
        chk("post_rst_instr", 104, instr, 32'h2408_0001);
        chk("post_rst_stall_drop", 104, {31'h0, stall}, 32'h0);
        @(negedge clk); drive_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
